l1_mem_arbiter: RTL

- Shares one word-serial memory port between two L1 cache cores: requester 0 is the I-cache and requester 1 is the D-cache.
- Sits between each cache's memory-side port (mem_req_*/mem_resp_*) and the backing memory/bus.
- Arbitration is round-robin. A grant locks for one full line burst (fill or writeback) so that words from the two caches never interleave.
- Reports grant state and event pulses for the performance monitors.

---
 rtl/l1_arb_pkg.sv | 14 +
 rtl/rr_arbiter_2.sv | 17 +
 rtl/l1_mem_arbiter.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/l1_arb_pkg.sv
// Shared types and constants for the L1 memory-port arbiter.
package l1_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    HOLD = 2'd2
  } arb_state_t;

  localparam int REQ_I   = 0;  // I-cache requester index
  localparam int REQ_D   = 1;  // D-cache requester index
  localparam int NUM_REQ = 2;

endpackage

// File: rtl/rr_arbiter_2.sv
// Combinational 2-way round-robin pick: the sole requester wins, and on
// contention the requester that did not own the port last time wins.
module rr_arbiter_2
  import l1_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               last_owner_i,
  output logic [NUM_REQ-1:0] pick_o
);

  // one-hot pick, empty when nobody requests
  always_comb begin
    pick_o = req_i;
    if (&req_i) pick_o = last_owner_i ? 2'b01 : 2'b10;
  end

endmodule

// File: rtl/l1_mem_arbiter.sv
// Shares one word-serial memory port between the I-cache (r0) and the
// D-cache (r1). A grant is locked for a whole line burst so words from
// the two caches never interleave; a short burst releases after the owner
// has been idle for HOLD_CYCLES cycles.
module l1_mem_arbiter
  import l1_arb_pkg::*;
#(
  parameter int BURST_WORDS = 4,
  parameter int HOLD_CYCLES = 2,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32
)(
  input  logic              clk,
  input  logic              rst,
  input  logic              r0_req_valid,
  input  logic              r0_req_we,
  input  logic [ADDR_W-1:0] r0_req_addr,
  input  logic [DATA_W-1:0] r0_req_wdata,
  output logic              r0_resp_valid,
  output logic [DATA_W-1:0] r0_resp_rdata,
  input  logic              r1_req_valid,
  input  logic              r1_req_we,
  input  logic [ADDR_W-1:0] r1_req_addr,
  input  logic [DATA_W-1:0] r1_req_wdata,
  output logic              r1_resp_valid,
  output logic [DATA_W-1:0] r1_resp_rdata,
  output logic              mem_req_valid,
  output logic              mem_req_we,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [DATA_W-1:0] mem_req_wdata,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_resp_rdata,
  output logic [1:0]        gnt,
  output logic              conflict_pulse,
  output logic              protocol_err_pulse
);

  localparam int WCW = (BURST_WORDS > 1) ? $clog2(BURST_WORDS) : 1;
  localparam int ICW = $clog2(HOLD_CYCLES + 1);
  localparam logic [WCW-1:0] LAST_WORD = WCW'(BURST_WORDS - 1);
  localparam logic [ICW-1:0] HOLD_MAX  = ICW'(HOLD_CYCLES);

  arb_state_t         state_q, state_d;
  logic               owner_q, owner_d;           // 0 = I-cache, 1 = D-cache
  logic               last_owner_q, last_owner_d;
  logic [WCW-1:0]     word_cnt_q, word_cnt_d;
  logic [ICW-1:0]     idle_cnt_q, idle_cnt_d;
  logic [ICW-1:0]     idle_inc;
  logic [NUM_REQ-1:0] req_vld, pick;
  logic               active, resp_hit;
  logic               own_vld, own_we;
  logic [ADDR_W-1:0]  own_addr;
  logic [DATA_W-1:0]  own_wdata;

  assign req_vld  = {r1_req_valid, r0_req_valid};
  assign active   = (state_q != IDLE);
  assign resp_hit = (state_q == BUSY) && mem_resp_valid;
  assign idle_inc = idle_cnt_q + ICW'(1);

  rr_arbiter_2 u_rr (
    .req_i        (req_vld),
    .last_owner_i (last_owner_q),
    .pick_o       (pick)
  );

  // select the current owner's request fields
  always_comb begin
    own_vld   = r0_req_valid;
    own_we    = r0_req_we;
    own_addr  = r0_req_addr;
    own_wdata = r0_req_wdata;
    if (owner_q == 1'(REQ_D)) begin
      own_vld   = r1_req_valid;
      own_we    = r1_req_we;
      own_addr  = r1_req_addr;
      own_wdata = r1_req_wdata;
    end
  end

  // memory side follows the owner only while a grant is held; zero otherwise
  assign mem_req_valid = active && own_vld;
  assign mem_req_we    = active && own_we;
  assign mem_req_addr  = active ? own_addr  : '0;
  assign mem_req_wdata = active ? own_wdata : '0;
  assign gnt           = !active ? 2'b00 : (owner_q ? 2'b10 : 2'b01);

  // responses only go to the owner, and only while a word is outstanding
  assign r0_resp_valid = resp_hit && (owner_q == 1'(REQ_I));
  assign r1_resp_valid = resp_hit && (owner_q == 1'(REQ_D));
  assign r0_resp_rdata = r0_resp_valid ? mem_resp_rdata : '0;
  assign r1_resp_rdata = r1_resp_valid ? mem_resp_rdata : '0;

  // event pulses are masked during reset so every output reads zero
  assign conflict_pulse     = !rst && (state_q == IDLE) && (&req_vld);
  assign protocol_err_pulse = !rst && mem_resp_valid && (state_q != BUSY);

  // next-state: arbitrate in IDLE, count burst words in BUSY, idle-timeout in HOLD
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    word_cnt_d   = word_cnt_q;
    idle_cnt_d   = idle_cnt_q;
    case (state_q)
      IDLE: begin
        if (|req_vld) begin
          state_d    = BUSY;
          owner_d    = (pick == 2'b10);
          word_cnt_d = '0;
          idle_cnt_d = '0;
        end
      end
      BUSY: begin
        if (mem_resp_valid) begin
          idle_cnt_d = '0;
          if (word_cnt_q == LAST_WORD) begin
            state_d      = IDLE;
            last_owner_d = owner_q;
            word_cnt_d   = '0;
          end else begin
            state_d    = HOLD;
            word_cnt_d = word_cnt_q + WCW'(1);
          end
        end
      end
      HOLD: begin
        if (own_vld) begin
          state_d    = BUSY;
          idle_cnt_d = '0;
        end else if (idle_inc == HOLD_MAX) begin
          state_d      = IDLE;
          last_owner_d = owner_q;
          word_cnt_d   = '0;
          idle_cnt_d   = '0;
        end else begin
          idle_cnt_d = idle_inc;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // state registers; last_owner resets to D so the I-cache wins first contention
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      word_cnt_q   <= '0;
      idle_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      word_cnt_q   <= word_cnt_d;
      idle_cnt_q   <= idle_cnt_d;
    end
  end

endmodule
